// File: rtl/adder_sched_pkg.sv
`default_nettype none
// ============================================================================
//  adder_sched_pkg : shared types and round-robin pick helper for adder_scheduler
//  Rev 1.0
// ============================================================================
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  // The pick helper works on a fixed-size vector; callers zero-extend up to 32 requesters.
  localparam int RR_MAXN = 32;
  localparam int RR_IW   = 5;

  // One-hot grant of the first set request at or after ptr, wrapping at n.
  function automatic logic [RR_MAXN-1:0] rr_pick(
    input logic [RR_MAXN-1:0] req,
    input logic [RR_IW-1:0]   ptr,
    input logic [RR_IW:0]     n
  );
    logic [RR_MAXN-1:0] pick;
    logic               found;
    logic [RR_IW:0]     idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAXN; k++) begin
      idx = {1'b0, ptr} + (RR_IW+1)'(k);
      if (idx >= n) idx = idx - n;
      if (!found && (k < int'(n)) && req[idx[RR_IW-1:0]]) begin
        pick[idx[RR_IW-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  rr_arbiter : combinational round-robin arbiter, one-hot grant plus index
//  Rev 1.0
// ============================================================================
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [RR_MAXN-1:0] w_pick;

  always_comb begin
    w_pick = rr_pick(RR_MAXN'(req_i), RR_IW'(ptr_i), (RR_IW+1)'(NREQ));
    gnt_o  = w_pick[NREQ-1:0];
    any_o  = |w_pick;
    idx_o  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) idx_o = IW'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/adder_scheduler.sv
`default_nettype none
// ============================================================================
//  adder_scheduler : round-robin sharing of one Adder counter between requesters
//  Rev 1.0
// ============================================================================
module adder_scheduler
  import adder_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int LW    = 3
) (
  input  logic               aclk,
  input  logic               srst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    op_clr,
  input  logic [NREQ*LW-1:0] op_len,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [WIDTH-1:0]   result,
  output logic               add_clr,
  output logic               add_inc,
  input  logic [WIDTH-1:0]   add_out
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             clr_q, clr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [NREQ-1:0]  w_arb_gnt;
  logic [IW-1:0]    w_arb_idx;
  logic             w_arb_any;
  logic [LW-1:0]    w_len;
  logic             w_fsm_clr;
  logic             w_fsm_inc;
  logic [NREQ-1:0]  w_done;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (w_arb_gnt),
    .idx_o (w_arb_idx),
    .any_o (w_arb_any)
  );

  always_comb w_len = op_len[w_arb_idx*LW +: LW];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    clr_d     = clr_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    w_fsm_clr = 1'b0;
    w_fsm_inc = 1'b0;
    w_done    = '0;
    unique case (state_q)
      IDLE: begin
        if (w_arb_any) begin
          gnt_d   = w_arb_gnt;
          idx_d   = w_arb_idx;
          clr_d   = op_clr[w_arb_idx];
          cnt_d   = w_len;
          // A zero-length increment is a plain read: skip straight to capture.
          state_d = (!op_clr[w_arb_idx] && (w_len == '0)) ? CAPT : EXEC;
        end
      end
      EXEC: begin
        if (clr_q) begin
          w_fsm_clr = 1'b1;
          state_d   = CAPT;
        end else begin
          w_fsm_inc = 1'b1;
          cnt_d     = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) state_d = CAPT;
        end
      end
      CAPT: begin
        result_d = add_out;
        state_d  = DONE;
      end
      DONE: begin
        w_done  = gnt_q;
        gnt_d   = '0;
        ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
      clr_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      clr_q    <= clr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // srst also clears the shared counter; inc/done are masked so an aborted op
  // can never overlap the clear or report completion.
  assign add_clr = srst | w_fsm_clr;
  assign add_inc = w_fsm_inc & ~srst;
  assign done    = srst ? '0 : w_done;
  assign gnt     = gnt_q;
  assign result  = result_q;

endmodule
`default_nettype wire
